// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-FF synchronizer, mid-bit sampling, one-cycle valid / error strobes.
// Define UART_RX_PARITY_EN to insert a parity bit after bit 7 (PARITY_ODD selects the sense).
//
// state    | meaning
// S_IDLE   | line idle, waiting for a falling edge on rx_s
// S_START  | counting to mid start bit to reject glitches
// S_DATA   | sampling 8 data bits LSB first at mid-bit
// S_PARITY | sampling the parity bit (UART_RX_PARITY_EN only)
// S_STOP   | sampling the stop bit, delivering the byte or flagging an error
// S_BREAK  | line held low after a bad stop, waiting for it to return high
module uart_rx #(
   parameter int CYCLES_PER_BIT = 86,
   parameter int HALF_BIT       = CYCLES_PER_BIT / 2
`ifdef UART_RX_PARITY_EN
   ,
   parameter bit PARITY_ODD     = 1'b0
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_serial,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       rx_frame_err,
   output logic       rx_parity_err
);

   localparam logic [8:0] CNT_BIT  = 9'(CYCLES_PER_BIT);
   localparam logic [8:0] CNT_HALF = 9'(HALF_BIT);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef UART_RX_PARITY_EN
      S_PARITY,
`endif
      S_STOP,
      S_BREAK
   } state_t;

   state_t     state;
   logic [1:0] sync;
   logic       rx_s;
   logic [8:0] cnt;
   logic [2:0] idx;
   logic [7:0] shift;
`ifdef UART_RX_PARITY_EN
   logic       par_bad;
`endif

   assign rx_s = sync[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) sync <= 2'b11;
      else     sync <= {sync[0], rx_serial};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cnt          <= 9'd0;
         idx          <= 3'd0;
         shift        <= 8'h00;
         rx_data      <= 8'h00;
         rx_valid     <= 1'b0;
         rx_busy      <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad       <= 1'b0;
         rx_parity_err <= 1'b0;
`endif
      end else begin
         rx_valid     <= 1'b0;
         rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         rx_parity_err <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               cnt <= 9'd0;
               idx <= 3'd0;
`ifdef UART_RX_PARITY_EN
               par_bad <= 1'b0;
`endif
               if (!rx_s) begin
                  state   <= S_START;
                  rx_busy <= 1'b1;
               end
            end
            S_START: begin
               if (cnt == CNT_HALF) begin
                  cnt <= 9'd0;
                  if (!rx_s) begin
                     state <= S_DATA;
                  end else begin
                     state   <= S_IDLE;
                     rx_busy <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + 9'd1;
               end
            end
            S_DATA: begin
               if (cnt == CNT_BIT) begin
                  cnt        <= 9'd0;
                  shift[idx] <= rx_s;
                  idx        <= idx + 3'd1;
                  if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PARITY;
`else
                     state <= S_STOP;
`endif
                  end
               end else begin
                  cnt <= cnt + 9'd1;
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
               if (cnt == CNT_BIT) begin
                  cnt     <= 9'd0;
                  par_bad <= (^shift) ^ rx_s ^ PARITY_ODD;
                  state   <= S_STOP;
               end else begin
                  cnt <= cnt + 9'd1;
               end
            end
`endif
            S_STOP: begin
               if (cnt == CNT_BIT) begin
                  cnt <= 9'd0;
                  if (rx_s) begin
                     // Leaving at mid-stop lets a back-to-back start bit be caught.
                     state   <= S_IDLE;
                     rx_busy <= 1'b0;
`ifdef UART_RX_PARITY_EN
                     if (par_bad) begin
                        rx_parity_err <= 1'b1;
                     end else begin
                        rx_data  <= shift;
                        rx_valid <= 1'b1;
                     end
`else
                     rx_data  <= shift;
                     rx_valid <= 1'b1;
`endif
                  end else begin
                     rx_frame_err <= 1'b1;
                     state        <= S_BREAK;
                  end
               end else begin
                  cnt <= cnt + 9'd1;
               end
            end
            S_BREAK: begin
               if (rx_s) begin
                  state   <= S_IDLE;
                  rx_busy <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign rx_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial driver, scoreboard of expected bytes and valid cycles.
module tb_uart_rx;

   localparam int CPB = 86;
   localparam int BIT = CPB + 1;
`ifdef UART_RX_PARITY_EN
   localparam int PAR_BITS = 1;
`else
   localparam int PAR_BITS = 0;
`endif
   // pin edge to rx_valid: 2 sync + half start + data/parity/stop bits + detect/register
   localparam int LAT = 2 + CPB / 2 + (9 + PAR_BITS) * BIT + 2;

   typedef struct {
      logic [7:0] data;
      int         cyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_serial;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       rx_frame_err;
   logic       rx_parity_err;

   exp_t       exp_q[$];
   exp_t       e;
   int         cyc = 0;
   int         compared = 0;
   int         mismatched = 0;
   int         valid_cnt = 0;
   int         fe_cnt = 0;
   int         pe_cnt = 0;
   logic [7:0] last_good;

   uart_rx dut (
      .clk           (clk),
      .rst           (rst),
      .rx_serial     (rx_serial),
      .rx_data       (rx_data),
      .rx_valid      (rx_valid),
      .rx_busy       (rx_busy),
      .rx_frame_err  (rx_frame_err),
      .rx_parity_err (rx_parity_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!rst) begin
         if (rx_frame_err) fe_cnt++;
         if (rx_parity_err) pe_cnt++;
         if (rx_valid) begin
            valid_cnt++;
            compared++;
            if (exp_q.size() == 0) begin
               mismatched++;
               $display("FAIL unexpected_valid: data %h at cycle %0d, no byte expected", rx_data, cyc);
            end else begin
               e = exp_q.pop_front();
               if (rx_data !== e.data) begin
                  mismatched++;
                  $display("FAIL sb_data: got %h expected %h", rx_data, e.data);
               end
               compared++;
               if (cyc != e.cyc) begin
                  mismatched++;
                  $display("FAIL sb_valid_cycle: got %0d expected %0d", cyc, e.cyc);
               end
            end
         end
      end
   end

   task automatic hold();
      repeat (BIT) @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // par < 0 sends the correct even parity bit (only when parity is built in)
   task automatic send_frame(input logic [7:0] d, input logic stop, input int par, input bit good);
      exp_t x;
      x.data = d;
      x.cyc  = cyc + LAT;
      if (good) exp_q.push_back(x);
      rx_serial = 1'b0;
      hold();
      for (int i = 0; i < 8; i++) begin
         rx_serial = d[i];
         hold();
      end
`ifdef UART_RX_PARITY_EN
      rx_serial = (par < 0) ? ^d : par[0];
      hold();
`else
      if (par > 0) $display("note: parity bit ignored in this build");
`endif
      rx_serial = stop;
      hold();
   endtask

   task automatic test_reset();
      compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      compared++; if (rx_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
      compared++; if (rx_frame_err !== 1'b0) begin mismatched++; $display("FAIL reset_frame_err: got %b expected 0", rx_frame_err); end
      compared++; if (rx_parity_err !== 1'b0) begin mismatched++; $display("FAIL reset_parity_err: got %b expected 0", rx_parity_err); end
      last_good = 8'h00;
   endtask

   task automatic test_loopback();
      int s, v0;
      v0 = valid_cnt;
      s  = cyc;
      fork
         send_frame(8'hA5, 1'b1, -1, 1'b1);
         begin
            while (cyc < s + LAT - 1) @(negedge clk);
            compared++; if (rx_busy !== 1'b1) begin mismatched++; $display("FAIL loop_busy_at_stop: got %b expected 1", rx_busy); end
            @(negedge clk);
            compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL loop_busy_after_stop: got %b expected 0", rx_busy); end
            compared++; if (rx_data !== 8'hA5) begin mismatched++; $display("FAIL loop_data: got %h expected a5", rx_data); end
         end
      join
      idle(50);
      compared++; if (valid_cnt - v0 != 1) begin mismatched++; $display("FAIL loop_valid_count: got %0d expected 1", valid_cnt - v0); end
      last_good = 8'hA5;
   endtask

   task automatic test_glitch();
      int v0, f0, n;
      v0 = valid_cnt;
      f0 = fe_cnt;
      n  = 0;
      fork
         begin
            rx_serial = 1'b0;
            idle(20);
            rx_serial = 1'b1;
         end
         repeat (150) begin
            @(negedge clk);
            if (rx_busy) n++;
         end
      join
      compared++; if (n != 44) begin mismatched++; $display("FAIL glitch_busy_cycles: got %0d expected 44", n); end
      compared++; if (valid_cnt != v0) begin mismatched++; $display("FAIL glitch_valid: got %0d pulses expected 0", valid_cnt - v0); end
      compared++; if (fe_cnt != f0) begin mismatched++; $display("FAIL glitch_frame_err: got %0d pulses expected 0", fe_cnt - f0); end
   endtask

   task automatic test_break();
      int v0, f0;
      v0 = valid_cnt;
      f0 = fe_cnt;
      send_frame(8'h3C, 1'b0, -1, 1'b0);
      idle(3000);
      rx_serial = 1'b1;
      idle(100);
      compared++; if (fe_cnt - f0 != 1) begin mismatched++; $display("FAIL break_frame_err: got %0d pulses expected 1", fe_cnt - f0); end
      compared++; if (valid_cnt != v0) begin mismatched++; $display("FAIL break_valid: got %0d pulses expected 0", valid_cnt - v0); end
      compared++; if (rx_data !== last_good) begin mismatched++; $display("FAIL break_data_held: got %h expected %h", rx_data, last_good); end
      compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL break_busy_idle: got %b expected 0", rx_busy); end
      send_frame(8'h81, 1'b1, -1, 1'b1);
      idle(20);
      compared++; if (valid_cnt - v0 != 1) begin mismatched++; $display("FAIL break_recover_count: got %0d expected 1", valid_cnt - v0); end
      compared++; if (rx_data !== 8'h81) begin mismatched++; $display("FAIL break_recover_data: got %h expected 81", rx_data); end
      last_good = 8'h81;
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = valid_cnt;
      send_frame(8'h00, 1'b1, -1, 1'b1);
      send_frame(8'hFF, 1'b1, -1, 1'b1);
      idle(20);
      compared++; if (valid_cnt - v0 != 2) begin mismatched++; $display("FAIL b2b_count: got %0d expected 2", valid_cnt - v0); end
      compared++; if (rx_data !== 8'hFF) begin mismatched++; $display("FAIL b2b_data: got %h expected ff", rx_data); end
      last_good = 8'hFF;
   endtask

   task automatic test_reset_mid();
      int s, v0;
      v0 = valid_cnt;
      s  = cyc;
      fork
         send_frame(8'h5A, 1'b1, -1, 1'b0);
         begin
            while (cyc < s + 5 * BIT + 40) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            compared++; if (rx_busy !== 1'b0) begin mismatched++; $display("FAIL rstmid_busy: got %b expected 0", rx_busy); end
            compared++; if (rx_data !== 8'h00) begin mismatched++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
            compared++; if (rx_valid !== 1'b0 || rx_frame_err !== 1'b0) begin mismatched++; $display("FAIL rstmid_pulses: got valid %b ferr %b expected 0 0", rx_valid, rx_frame_err); end
         end
      join
      idle(5);
      rst = 1'b0;
      idle(50);
      last_good = 8'h00;
      compared++; if (valid_cnt != v0) begin mismatched++; $display("FAIL rstmid_no_valid: got %0d pulses expected 0", valid_cnt - v0); end
      send_frame(8'hC3, 1'b1, -1, 1'b1);
      idle(20);
      compared++; if (rx_data !== 8'hC3) begin mismatched++; $display("FAIL rstmid_fresh_data: got %h expected c3", rx_data); end
      last_good = 8'hC3;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int v0, p0;
      v0 = valid_cnt;
      p0 = pe_cnt;
      send_frame(8'h07, 1'b1, 1, 1'b1);
      send_frame(8'h07, 1'b1, 0, 1'b0);
      idle(20);
      compared++; if (valid_cnt - v0 != 1) begin mismatched++; $display("FAIL parity_valid: got %0d expected 1", valid_cnt - v0); end
      compared++; if (pe_cnt - p0 != 1) begin mismatched++; $display("FAIL parity_err: got %0d expected 1", pe_cnt - p0); end
      compared++; if (rx_data !== 8'h07) begin mismatched++; $display("FAIL parity_data: got %h expected 07", rx_data); end
   endtask
`endif

   initial begin
      rst       = 1'b1;
      rx_serial = 1'b1;
      idle(5);
      test_reset();
      rst = 1'b0;
      idle(10);
      test_loopback();
      test_glitch();
      test_break();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      idle(20);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL sb_leftover: got %0d bytes never delivered expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
